// File: rtl/sd_cmd_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sd_cmd_issue_ctrl
// Brief    : Sequences one SD command on the CMD engine, from the register write
//            through response hand-off and status posting. Setting the
//            SD_CMD_INDEX_CHECK_EN macro adds the response index comparator.
// Revision : 1.0  initial release
// ============================================================================
module sd_cmd_issue_ctrl #(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int TO_W           = 11
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         sw_reset_cmd,
   input  logic         cmd_wr,
   input  logic [5:0]   cmd_index_in,
   input  logic [1:0]   resp_type_in,
   input  logic         idx_chk_en_in,
   input  logic [31:0]  argument_in,
   input  logic         timeout_en_in,
   output logic         eng_start,
   output logic         eng_abort,
   output logic [5:0]   eng_index,
   output logic [31:0]  eng_argument,
   input  logic         eng_done,
   input  logic [127:0] eng_resp,
   output logic [127:0] resp_data,
   output logic         resp_valid,
   input  logic         resp_ack,
   output logic         cmd_inhibit,
   output logic         int_cmd_complete,
   output logic         err_cmd_timeout,
   output logic         err_cmd_index,
   output logic         cmd_rejected
);

   localparam logic [2:0] c_ST_IDLE  = 3'd0;
   localparam logic [2:0] c_ST_ISSUE = 3'd1;
   localparam logic [2:0] c_ST_WAIT  = 3'd2;
   localparam logic [2:0] c_ST_STORE = 3'd3;
   localparam logic [2:0] c_ST_DONE  = 3'd4;

   localparam logic [TO_W-1:0] c_TO_MAX = TO_W'(TIMEOUT_CYCLES);

   logic [2:0]      r_state;
   logic [2:0]      w_next;
   logic [TO_W-1:0] r_count;
   logic [5:0]      r_index;
   logic [31:0]     r_argument;
   logic [1:0]      r_type;
   logic [127:0]    r_resp;
   logic            w_timeout;
   logic            w_idx_err;

   // A response arriving on the terminal-count cycle still completes the command.
   assign w_timeout = (r_count == c_TO_MAX) && (r_type != 2'b00) && !eng_done;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= c_ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      if (sw_reset_cmd) begin
         w_next = c_ST_IDLE;
      end else begin
         case (r_state)
            c_ST_IDLE:  if (cmd_wr) w_next = c_ST_ISSUE;
            c_ST_ISSUE: w_next = c_ST_WAIT;
            c_ST_WAIT: begin
               if (eng_done) begin
                  w_next = (r_type == 2'b00) ? c_ST_DONE : c_ST_STORE;
               end else if (w_timeout) begin
                  w_next = c_ST_IDLE;
               end
            end
            c_ST_STORE: if (resp_ack) w_next = c_ST_DONE;
            c_ST_DONE:  w_next = c_ST_IDLE;
            default:    w_next = c_ST_IDLE;
         endcase
      end
   end

   always_comb begin
      eng_start        = 1'b0;
      eng_abort        = 1'b0;
      resp_valid       = 1'b0;
      int_cmd_complete = 1'b0;
      err_cmd_timeout  = 1'b0;
      err_cmd_index    = 1'b0;
      cmd_inhibit      = (r_state != c_ST_IDLE);
      cmd_rejected     = cmd_wr && (r_state != c_ST_IDLE);
      case (r_state)
         c_ST_ISSUE: begin
            eng_start = !sw_reset_cmd;
            eng_abort = sw_reset_cmd;
         end
         c_ST_WAIT: begin
            eng_abort       = sw_reset_cmd || w_timeout;
            err_cmd_timeout = !sw_reset_cmd && w_timeout && timeout_en_in;
         end
         c_ST_STORE: resp_valid = !sw_reset_cmd;
         c_ST_DONE: begin
            int_cmd_complete = !sw_reset_cmd;
            err_cmd_index    = !sw_reset_cmd && w_idx_err;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_count    <= '0;
         r_index    <= '0;
         r_argument <= '0;
         r_type     <= '0;
         r_resp     <= '0;
      end else begin
         if ((r_state == c_ST_IDLE) && cmd_wr && !sw_reset_cmd) begin
            r_index    <= cmd_index_in;
            r_argument <= argument_in;
            r_type     <= resp_type_in;
         end
         if (r_state == c_ST_ISSUE) begin
            r_count <= '0;
         end else if ((r_state == c_ST_WAIT) && (r_count != c_TO_MAX)) begin
            r_count <= r_count + TO_W'(1);
         end
         if ((r_state == c_ST_WAIT) && eng_done && !sw_reset_cmd) begin
            r_resp <= eng_resp;
         end
      end
   end

`ifdef SD_CMD_INDEX_CHECK_EN
   logic r_idx_chk;
   logic r_idx_err;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_idx_chk <= 1'b0;
         r_idx_err <= 1'b0;
      end else begin
         if ((r_state == c_ST_IDLE) && cmd_wr && !sw_reset_cmd) begin
            r_idx_chk <= idx_chk_en_in;
         end
         if (r_state == c_ST_ISSUE) begin
            r_idx_err <= 1'b0;
         end else if ((r_state == c_ST_WAIT) && eng_done && !sw_reset_cmd) begin
            // Only 48-bit response formats carry the echoed index in [45:40].
            r_idx_err <= r_type[1] && r_idx_chk && (eng_resp[45:40] != r_index);
         end
      end
   end

   assign w_idx_err = r_idx_err;
`else
   logic w_unused_idx_chk;
   assign w_unused_idx_chk = idx_chk_en_in;
   assign w_idx_err        = 1'b0;
`endif

   assign eng_index    = r_index;
   assign eng_argument = r_argument;
   assign resp_data    = r_resp;

endmodule
`default_nettype wire

// File: tb/tb_sd_cmd_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sd_cmd_issue_ctrl
// Brief    : Randomized self-checking bench for sd_cmd_issue_ctrl; expected
//            outputs come from a per-transaction cycle schedule.
// Revision : 1.0  initial release
// ============================================================================
module tb_sd_cmd_issue_ctrl;

   localparam int c_TO = 1024;

   logic         clock = 1'b0;
   logic         reset = 1'b0;
   logic         sw_reset_cmd = 1'b0;
   logic         cmd_wr = 1'b0;
   logic [5:0]   cmd_index_in = '0;
   logic [1:0]   resp_type_in = '0;
   logic         idx_chk_en_in = 1'b0;
   logic [31:0]  argument_in = '0;
   logic         timeout_en_in = 1'b0;
   logic         eng_start;
   logic         eng_abort;
   logic [5:0]   eng_index;
   logic [31:0]  eng_argument;
   logic         eng_done = 1'b0;
   logic [127:0] eng_resp = '0;
   logic [127:0] resp_data;
   logic         resp_valid;
   logic         resp_ack = 1'b0;
   logic         cmd_inhibit;
   logic         int_cmd_complete;
   logic         err_cmd_timeout;
   logic         err_cmd_index;
   logic         cmd_rejected;

   int total = 0;
   int bad   = 0;

   sd_cmd_issue_ctrl #(.TIMEOUT_CYCLES(c_TO), .TO_W(11)) dut (
      .clock(clock), .reset(reset), .sw_reset_cmd(sw_reset_cmd), .cmd_wr(cmd_wr),
      .cmd_index_in(cmd_index_in), .resp_type_in(resp_type_in),
      .idx_chk_en_in(idx_chk_en_in), .argument_in(argument_in),
      .timeout_en_in(timeout_en_in), .eng_start(eng_start), .eng_abort(eng_abort),
      .eng_index(eng_index), .eng_argument(eng_argument), .eng_done(eng_done),
      .eng_resp(eng_resp), .resp_data(resp_data), .resp_valid(resp_valid),
      .resp_ack(resp_ack), .cmd_inhibit(cmd_inhibit),
      .int_cmd_complete(int_cmd_complete), .err_cmd_timeout(err_cmd_timeout),
      .err_cmd_index(err_cmd_index), .cmd_rejected(cmd_rejected)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   // {inhibit, start, abort, resp_valid, complete, err_timeout, err_index, rejected}
   function automatic logic [7:0] pulses();
      return {cmd_inhibit, eng_start, eng_abort, resp_valid, int_cmd_complete,
              err_cmd_timeout, err_cmd_index, cmd_rejected};
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // mode: 0 normal, 1 no response (timeout), 2 response on terminal count, 3 sw reset
   // ten_sel: 0/1 forces timeout_en, 2 randomizes it
   task automatic run_txn(input int mode, input int ten_sel);
      logic [5:0]   idx;
      logic [31:0]  arg;
      logic [1:0]   typ;
      logic         chk, ten, idx_bad, timed_out;
      logic [127:0] resp;
      logic [7:0]   ev;
      int d, a, done_c, to_c, cpl_c, busy_end, wait_end, rej_c, sw_c;
      bit live;

      idx  = 6'($urandom);
      arg  = $urandom;
      typ  = 2'($urandom);
      chk  = 1'($urandom);
      ten  = (ten_sel == 2) ? 1'($urandom) : 1'(ten_sel);
      d    = $urandom_range(0, 12);
      a    = $urandom_range(0, 4);
      if (mode == 1) begin
         if (typ == 2'b00) typ = 2'b01;
         d = 100000;
      end
      if (mode == 2) begin
         if (typ == 2'b00) typ = 2'b11;
         d = c_TO;
      end
      resp = rnd128();
      if ($urandom_range(0, 1) == 1) resp[45:40] = idx;
`ifdef SD_CMD_INDEX_CHECK_EN
      idx_bad = typ[1] && chk && (resp[45:40] != idx);
`else
      idx_bad = 1'b0;
`endif
      done_c    = 2 + d;
      to_c      = 2 + c_TO;
      timed_out = (typ != 2'b00) && (done_c > to_c);
      if (timed_out) begin
         cpl_c    = -1;
         busy_end = to_c;
         wait_end = to_c;
      end else begin
         cpl_c    = (typ == 2'b00) ? done_c + 1 : done_c + 2 + a;
         busy_end = cpl_c;
         wait_end = done_c;
      end
      sw_c  = (mode == 3) ? $urandom_range(1, busy_end) : -1;
      rej_c = -1;
      if (mode == 3) begin
         if (sw_c > 1 && $urandom_range(0, 1) == 1) rej_c = $urandom_range(1, sw_c - 1);
      end else begin
         case ($urandom_range(0, 3))
            0: rej_c = -1;
            1: rej_c = busy_end;
            default: rej_c = $urandom_range(1, busy_end);
         endcase
      end

      for (int c = 0; c <= busy_end + 2; c++) begin
         live          = (sw_c < 0) || (c < sw_c);
         cmd_wr        = (c == 0) || (c == rej_c);
         cmd_index_in  = (c == 0) ? idx : idx + 6'd1;
         argument_in   = (c == 0) ? arg : ~arg;
         resp_type_in  = (c == 0) ? typ : ~typ;
         idx_chk_en_in = (c == 0) ? chk : 1'($urandom);
         timeout_en_in = ten;
         sw_reset_cmd  = (c == sw_c);
         eng_done      = live && !timed_out && (c == done_c);
         eng_resp      = (c == done_c) ? resp : rnd128();
         resp_ack      = live && (typ != 2'b00) && !timed_out && (c == done_c + 1 + a);

         ev = '0;
         if (sw_c >= 0 && c == sw_c) begin
            ev[7] = 1'b1;
            ev[5] = (c == 1) || (c >= 2 && c <= wait_end);
         end else if (sw_c < 0 || c < sw_c) begin
            ev[7] = (c >= 1) && (c <= busy_end);
            ev[6] = (c == 1);
            ev[5] = timed_out && (c == to_c);
            ev[4] = (typ != 2'b00) && !timed_out && (c >= done_c + 1) && (c <= done_c + 1 + a);
            ev[3] = (c == cpl_c);
            ev[2] = ev[5] && ten;
            ev[1] = (c == cpl_c) && idx_bad;
            ev[0] = (c == rej_c);
         end

         @(negedge clock);
         check("pulses", 128'(pulses()), 128'(ev));
         if (c == 1) begin
            check("eng_index", 128'(eng_index), 128'(idx));
            check("eng_argument", 128'(eng_argument), 128'(arg));
         end
         if (!timed_out && c == done_c + 1 && (sw_c < 0 || sw_c > done_c))
            check("resp_data", resp_data, resp);
         @(posedge clock);
         #1;
      end
      cmd_wr       = 1'b0;
      sw_reset_cmd = 1'b0;
      eng_done     = 1'b0;
      resp_ack     = 1'b0;
      check("eng_index_hold", 128'(eng_index), 128'(idx));
      check("eng_argument_hold", 128'(eng_argument), 128'(arg));
   endtask

   initial begin
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("rst_pulses", 128'(pulses()), 128'(0));
      check("rst_resp_data", resp_data, 128'(0));
      check("rst_eng_index", 128'(eng_index), 128'(0));
      check("rst_eng_argument", 128'(eng_argument), 128'(0));
      reset = 1'b1;
      @(posedge clock);
      #1;

      run_txn(1, 1);
      run_txn(1, 0);
      run_txn(2, 2);
      for (int n = 0; n < 40; n++) begin
         run_txn(($urandom_range(0, 3) == 0) ? 3 : 0, 2);
      end

      // Asynchronous reset while the engine is in flight.
      cmd_index_in = 6'd33;
      argument_in  = 32'hDEAD_BEEF;
      resp_type_in = 2'b10;
      cmd_wr       = 1'b1;
      @(posedge clock);
      #1;
      cmd_wr = 1'b0;
      repeat (4) @(posedge clock);
      #2;
      reset = 1'b0;
      #1;
      check("arst_pulses", 128'(pulses()), 128'(0));
      check("arst_resp_data", resp_data, 128'(0));
      check("arst_eng_index", 128'(eng_index), 128'(0));
      check("arst_eng_argument", 128'(eng_argument), 128'(0));
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      @(negedge clock);
      check("arst_idle", 128'(pulses()), 128'(0));
      @(posedge clock);
      #1;
      run_txn(0, 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
